// File: rtl/mem_req_issue.sv
// mem_req_issue: in-order load/store issue queue between EX and a data memory with addr_ok/data_ok strobes
// Ports: clk/reset (sync, active-high); req_* EX request handshake; flush_i cancels in-flight work;
//        mem_* request channel and addr_ok/data_ok/rdata completion; resp_* MEM response; busy_o activity flag.
module mem_req_issue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_wr_i,
   input  logic [1:0]    req_size_i,
   input  logic          req_sext_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [31:0]   req_wdata_i,
   input  logic          flush_i,
   output logic          mem_req_o,
   output logic          mem_wr_o,
   output logic [1:0]    mem_size_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [3:0]    mem_wstrb_o,
   output logic [31:0]   mem_wdata_o,
   input  logic          mem_addr_ok_i,
   input  logic          mem_data_ok_i,
   input  logic [31:0]   mem_rdata_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic [31:0]   resp_data_o,
   output logic          resp_ale_o,
   output logic          busy_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // drops accumulate across repeated flushes while memory is slow, so give headroom
   localparam int DW = CW + 4;
   typedef struct packed {
      logic       wr;
      logic [1:0] size;
      logic       sext;
      logic [1:0] off;
   } meta_t;
   meta_t         meta_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, dptr_q, dptr_d;
   logic [CW-1:0] count_q, count_d, pend_q, pend_d;
   logic [DW-1:0] drop_q, drop_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic          ale_pend_q, ale_pend_d;
   logic [1:0]    size_n;
   logic          ale, alloc, ale_ok, pop, pop_q, drop_hit, fill;
   meta_t         hm;
   logic [31:0]   sh;
   assign size_n      = (req_size_i == 2'd3) ? 2'd2 : req_size_i;
   assign ale         = (size_n == 2'd1 & req_addr_i[0]) | (size_n == 2'd2 & |req_addr_i[1:0]);
   assign mem_req_o   = req_valid_i & ~ale & ~flush_i & ~reset & (count_q < CW'(DEPTH));
   assign mem_wr_o    = req_wr_i;
   assign mem_size_o  = size_n;
   assign mem_addr_o  = req_addr_i;
   assign mem_wstrb_o = ~req_wr_i ? 4'b0000 :
                        size_n == 2'd0 ? 4'b0001 << req_addr_i[1:0] :
                        size_n == 2'd1 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign mem_wdata_o = size_n == 2'd0 ? {4{req_wdata_i[7:0]}} :
                        size_n == 2'd1 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
   assign alloc       = mem_req_o & mem_addr_ok_i;
   // misaligned requests are only taken into an empty pipe so the exception stays in order
   assign ale_ok      = count_q == '0 & ~ale_pend_q & ~flush_i & ~reset;
   assign req_ready_o = ale ? ale_ok : alloc;
   assign resp_valid_o = ~reset & ~flush_i & (ale_pend_q | (count_q != '0 & done_q[head_q]));
   assign resp_ale_o  = ale_pend_q;
   assign pop         = resp_valid_o & resp_ready_i;
   assign pop_q       = pop & ~ale_pend_q;
   // memory completes in order: stale (flushed) transactions always return first
   assign drop_hit    = mem_data_ok_i & drop_q != '0;
   assign fill        = mem_data_ok_i & drop_q == '0 & pend_q != '0;
   assign hm          = meta_q[head_q];
   assign sh          = data_q[head_q] >> {hm.off, 3'b000};
   assign resp_data_o = (ale_pend_q | hm.wr) ? 32'h0 :
                        hm.size == 2'd0 ? {{24{hm.sext & sh[7]}}, sh[7:0]} :
                        hm.size == 2'd1 ? {{16{hm.sext & sh[15]}}, sh[15:0]} : sh;
   assign busy_o      = count_q != '0 | ale_pend_q | drop_q != '0;
   always_comb begin
      head_d     = head_q + PW'(pop_q);
      tail_d     = tail_q + PW'(alloc);
      dptr_d     = dptr_q + PW'(fill);
      count_d    = count_q + CW'(alloc) - CW'(pop_q);
      pend_d     = pend_q + CW'(alloc) - CW'(fill);
      drop_d     = drop_q - DW'(drop_hit);
      ale_pend_d = ale_pend_q ? ~pop : req_valid_i & ale & ale_ok;
      done_d     = done_q;
      if (fill) done_d[dptr_q] = 1'b1;
      if (pop_q) done_d[head_q] = 1'b0;
      if (alloc) done_d[tail_q] = 1'b0;
      if (flush_i) begin
         head_d     = '0;
         tail_d     = '0;
         dptr_d     = '0;
         count_d    = '0;
         pend_d     = '0;
         done_d     = '0;
         ale_pend_d = 1'b0;
         drop_d     = drop_q + DW'(pend_q) - DW'(drop_hit | fill);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         dptr_q     <= '0;
         count_q    <= '0;
         pend_q     <= '0;
         drop_q     <= '0;
         done_q     <= '0;
         ale_pend_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         dptr_q     <= dptr_d;
         count_q    <= count_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
         done_q     <= done_d;
         ale_pend_q <= ale_pend_d;
      end
   end
   always_ff @(posedge clk) begin
      if (alloc) meta_q[tail_q] <= '{wr: req_wr_i, size: size_n, sext: req_sext_i, off: req_addr_i[1:0]};
      if (fill) data_q[dptr_q] <= mem_rdata_i;
   end
endmodule

// File: tb/tb_mem_req_issue.sv
// tb_mem_req_issue: directed and randomized checks of mem_req_issue against a queue-based reference model
module tb_mem_req_issue;
   logic        clk = 1'b0, reset;
   logic        req_valid, req_ready, req_wr, req_sext, flush;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        resp_valid, resp_ready, resp_ale, busy;
   logic [31:0] resp_data;
   int errors = 0, checks = 0;
   typedef struct {
      bit wr;
      int size;
      bit sext;
      int off;
   } op_t;
   op_t live[$];
   logic [31:0] rdy[$];
   int drops = 0;
   bit ale_m = 0;
   always #5 clk = ~clk;
   mem_req_issue #(.DEPTH(4), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr), .req_size_i(req_size),
      .req_sext_i(req_sext), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .flush_i(flush),
      .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
      .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata), .mem_addr_ok_i(mem_addr_ok),
      .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
      .resp_ale_o(resp_ale), .busy_o(busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic int norm(input logic [1:0] s);
      return s == 2'd3 ? 2 : int'(s);
   endfunction
   function automatic bit is_ale(input logic [1:0] sz, input logic [31:0] a);
      int s = norm(sz);
      return (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
   endfunction
   function automatic logic [31:0] ext(input op_t o, input logic [31:0] d);
      logic [31:0] sh, v;
      if (o.wr) return 32'h0;
      sh = d >> (8 * o.off);
      if (o.size == 0) begin
         v = sh % 256;
         if (o.sext && v >= 128) v = v + 32'hFFFFFF00;
      end else if (o.size == 1) begin
         v = sh % 65536;
         if (o.sext && v >= 32768) v = v + 32'hFFFF0000;
      end else v = sh;
      return v;
   endfunction
   // One clock: check outputs against the model, advance the model, then move to the next falling edge.
   task automatic cycle();
      bit a, e_req, e_rdy, e_rv;
      int cnt, s, off;
      logic [31:0] strb, wd;
      #1;
      a     = is_ale(req_size, req_addr);
      cnt   = live.size() + rdy.size();
      s     = norm(req_size);
      off   = int'(req_addr % 4);
      e_req = req_valid && !a && !flush && !reset && cnt < 4;
      e_rdy = a ? (!reset && !flush && cnt == 0 && !ale_m) : (e_req && mem_addr_ok);
      e_rv  = !reset && !flush && (ale_m || rdy.size() > 0);
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      if (!reset) chk("busy", 32'(busy), 32'(cnt > 0 || ale_m || drops > 0));
      if (e_req) begin
         strb = !req_wr ? 0 : s == 0 ? (1 << off) : s == 1 ? (off >= 2 ? 12 : 3) : 15;
         wd   = s == 0 ? req_wdata[7:0] * 32'h01010101 : s == 1 ? req_wdata[15:0] * 32'h00010001 : req_wdata;
         chk("mem_wstrb", 32'(mem_wstrb), strb);
         chk("mem_wdata", mem_wdata, wd);
         chk("mem_addr", mem_addr, req_addr);
         chk("mem_wr_size", {29'd0, mem_wr, mem_size}, {29'd0, req_wr, 2'(s)});
      end
      if (e_rv) begin
         chk("resp_ale", 32'(resp_ale), 32'(ale_m));
         if (!ale_m) chk("resp_data", resp_data, rdy[0]);
      end
      if (reset) begin
         live.delete();
         rdy.delete();
         drops = 0;
         ale_m = 0;
      end else begin
         if (e_rv && resp_ready) begin
            if (ale_m) ale_m = 0;
            else void'(rdy.pop_front());
         end
         if (mem_data_ok) begin
            if (drops > 0) drops--;
            else if (live.size() > 0) rdy.push_back(ext(live.pop_front(), mem_rdata));
         end
         if (req_valid && e_rdy) begin
            if (a) ale_m = 1;
            else live.push_back('{wr: req_wr, size: s, sext: req_sext, off: off});
         end
         if (flush) begin
            drops += live.size();
            live.delete();
            rdy.delete();
            ale_m = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle();
      req_valid = 0; mem_addr_ok = 0; mem_data_ok = 0; resp_ready = 0; flush = 0; reset = 0;
   endtask
   task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
      req_valid = 1; req_wr = 0; req_size = sz; req_sext = sx; req_addr = a; mem_addr_ok = 1;
   endtask
   task automatic drain();
      idle();
      for (int i = 0; i < 40 && (live.size() + rdy.size() + drops > 0 || ale_m); i++) begin
         mem_data_ok = live.size() + drops > 0;
         mem_rdata   = $urandom;
         resp_ready  = 1;
         cycle();
      end
      idle();
      chk("drain_empty", 32'(live.size() + rdy.size() + drops + int'(ale_m)), 0);
   endtask
   initial begin
      idle();
      reset = 1; req_valid = 1; req_wr = 0; req_size = 2; req_sext = 0; req_addr = 0;
      req_wdata = 0; mem_rdata = 0; mem_addr_ok = 1;
      cycle();
      cycle();
      idle();
      cycle();
      // word load, data two cycles after acceptance
      load(32'h1004, 2, 0);
      cycle();
      idle();
      cycle();
      mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
      cycle();
      idle(); resp_ready = 1;
      #1;
      chk("w_load_data", resp_data, 32'hDEADBEEF);
      chk("w_load_ale", 32'(resp_ale), 0);
      cycle();
      // byte loads with and without sign extension
      for (int k = 1; k >= 0; k--) begin
         load(32'h1003, 0, 1'(k));
         cycle();
         idle(); mem_data_ok = 1; mem_rdata = 32'h80112233;
         cycle();
         idle(); resp_ready = 1;
         #1;
         chk("b_load_data", resp_data, k ? 32'hFFFFFF80 : 32'h00000080);
         cycle();
      end
      // half store
      idle(); req_valid = 1; req_wr = 1; req_size = 1; req_addr = 32'h2002; req_wdata = 32'h0000ABCD; mem_addr_ok = 1;
      #1;
      chk("h_store_strb", 32'(mem_wstrb), 32'hC);
      chk("h_store_wdata", mem_wdata, 32'hABCDABCD);
      cycle();
      idle(); mem_data_ok = 1; mem_rdata = $urandom;
      cycle();
      idle(); resp_ready = 1;
      #1;
      chk("h_store_resp", resp_data, 0);
      cycle();
      // misaligned word load with an empty queue
      idle(); load(32'h3002, 2, 0);
      #1;
      chk("ale_no_req", 32'(mem_req), 0);
      chk("ale_ready", 32'(req_ready), 1);
      cycle();
      idle();
      #1;
      chk("ale_resp", {30'd0, resp_valid, resp_ale}, 32'd3);
      resp_ready = 1;
      cycle();
      // five back-to-back loads into a four-deep queue
      idle();
      for (int i = 0; i < 4; i++) begin
         load(32'h4000 + 4 * i, 2, 0);
         cycle();
      end
      load(32'h4010, 2, 0);
      #1;
      chk("full_ready", 32'(req_ready), 0);
      cycle();
      mem_data_ok = 1; mem_rdata = 32'h11111111;
      cycle();
      mem_data_ok = 0; resp_ready = 1;
      #1;
      chk("full_pop_ready", 32'(req_ready), 0);
      cycle();
      resp_ready = 0;
      #1;
      chk("full_after_pop", 32'(req_ready), 1);
      cycle();
      drain();
      // flush with three loads in flight, then one fresh load
      for (int i = 0; i < 3; i++) begin
         load(32'h5000 + 4 * i, 2, 0);
         cycle();
      end
      idle(); flush = 1;
      cycle();
      idle(); load(32'h6000, 2, 0);
      cycle();
      idle();
      for (int i = 0; i < 4; i++) begin
         mem_data_ok = 1; mem_rdata = i == 3 ? 32'h55 : $urandom;
         cycle();
      end
      idle();
      #1;
      chk("flush_resp", {31'd0, resp_valid}, 1);
      chk("flush_data", resp_data, 32'h55);
      resp_ready = 1;
      cycle();
      idle();
      #1;
      chk("flush_single", 32'(resp_valid), 0);
      cycle();
      // stray data_ok while idle, then reset mid-operation
      mem_data_ok = 1; mem_rdata = $urandom;
      cycle();
      idle();
      for (int i = 0; i < 2; i++) begin
         load(32'h7000 + 4 * i, 2, 0);
         cycle();
      end
      idle(); reset = 1;
      cycle();
      idle();
      #1;
      chk("reset_busy", 32'(busy), 0);
      cycle();
      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         req_valid   = $urandom % 3 != 0;
         req_wr      = $urandom % 2 == 1;
         req_size    = 2'($urandom % 4);
         req_sext    = $urandom % 2 == 1;
         req_addr    = $urandom % 8 == 0 ? $urandom : ($urandom & 32'hFFFFFFFC) | ($urandom % 3 == 0 ? $urandom % 4 : 0);
         req_wdata   = $urandom;
         mem_addr_ok = $urandom % 2 == 1;
         mem_data_ok = live.size() + drops > 0 ? $urandom % 2 == 1 : $urandom % 8 == 0;
         mem_rdata   = $urandom;
         resp_ready  = $urandom % 4 != 0;
         flush       = $urandom % 40 == 0;
         reset       = $urandom % 700 == 0;
         cycle();
      end
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_req_issue.md
MEM_REQ_ISSUE -- requirements
Module: mem_req_issue

Interface
REQ-001 Parameter DEPTH, default 4, max outstanding memory requests; power of two, 2..16.
REQ-002 Parameter AW, default 32, data-memory address width.
REQ-003 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  EX-side request handshake.
REQ-006 req_wr  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  0 byte, 1 half, 2 word; 3 treated as word.
REQ-008 req_sext  in  1  sign-extend load result.
REQ-009 req_addr  in  AW  byte address.
REQ-010 req_wdata  in  32  unaligned store source (rkd value).
REQ-011 flush  in  1  exception/ertn cancel; discards all in-flight work.
REQ-012 mem_req, mem_wr, mem_size[1:0], mem_addr[AW], mem_wstrb[3:0], mem_wdata[31:0]  out  request channel.
REQ-013 mem_addr_ok, mem_data_ok  in  1  accept / in-order completion strobes; mem_rdata  in  32.
REQ-014 resp_valid/resp_ready  out/in  1/1  MEM-side response handshake.
REQ-015 resp_data  out  32  extended load data, 0 for stores; resp_ale  out  1  misaligned-access exception.
REQ-016 busy  out  1  any queue entry, pending ALE or nonzero drop count.

Function
REQ-017 ALE = (half & addr[0]) | (word & addr[1:0]!=0); byte never ALE.
REQ-018 mem_req = req_valid & ~ALE & ~flush & ~reset & (count < DEPTH); request fields driven combinationally from req_*.
REQ-019 wstrb: byte -> 0001<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111; loads -> 0000.
REQ-020 wdata: byte -> 4 copies of wdata[7:0]; half -> 2 copies of [15:0]; word -> as-is.
REQ-021 Non-ALE handshake completes only on mem_req & mem_addr_ok; req_ready = that product; entry {wr,size,sext,addr[1:0]} written at tail, tail++.
REQ-022 ALE request accepted (req_ready=1) only when count==0, ALE pending clear, ~flush; sets ale_pend, no memory request.
REQ-023 mem_data_ok with drop_cnt>0: drop_cnt--, data discarded.
REQ-024 mem_data_ok with drop_cnt==0 and an entry awaiting data: rdata stored at dptr, done bit set, dptr++.
REQ-025 mem_data_ok with nothing outstanding: ignored, no state change.
REQ-026 resp_valid = ale_pend | (count>0 & done[head]); ale_pend has priority; resp_ale = ale_pend.
REQ-027 Load extraction: shift rdata right by 8*addr[1:0], then zero/sign-extend per size, sext.
REQ-028 Response handshake pops head (head++, done cleared) or clears ale_pend.
REQ-029 Response may be presented same cycle as data_ok only from registered done bits, i.e., one cycle after data_ok earliest.
REQ-030 Pointers log2(DEPTH) bits, wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-031 Simultaneous alloc and pop: count unchanged; full queue with pop same cycle does not admit new request (ready uses pre-pop count).
REQ-032 flush: next cycle count=0, head=tail=dptr=0, done bits 0, ale_pend=0, drop_cnt += entries issued but not returned (minus one if data_ok same cycle and not already dropping).
REQ-033 During flush, resp_valid=0 and req_ready=0.
REQ-034 New requests allowed while drop_cnt>0; data_ok consumed by drops first (in-order memory).

Reset
REQ-035 Reset: head, tail, dptr, count, drop_cnt, done[], ale_pend cleared; mem_req, req_ready, resp_valid 0 during reset cycle.
REQ-036 Reset mid-operation abandons outstanding requests without drop accounting.

Verification
REQ-037 Word load addr 0x1004, addr_ok same cycle, data_ok +2 with rdata 0xDEADBEEF -> resp_data 0xDEADBEEF, resp_ale 0.
REQ-038 Byte load addr 0x1003, sext=1, rdata 0x80112233 -> resp_data 0xFFFFFF80; sext=0 -> 0x00000080.
REQ-039 Half store addr 0x2002, wdata 0x0000ABCD -> mem_wstrb 1100, mem_wdata 0xABCDABCD; response resp_data 0.
REQ-040 Word load addr 0x3002 with empty queue -> no mem_req, req_ready 1, next cycle resp_valid 1, resp_ale 1.
REQ-041 DEPTH=4, five back-to-back loads, no data_ok -> first four accepted, fifth req_ready 0 until a response pops.
REQ-042 Three loads issued, flush, then three data_ok + one new load's data_ok 0x55 -> first three discarded, single response 0x55.
